// File: rtl/pmt_histogrammer.sv
// pmt_histogrammer: per-channel PMT rising-edge hit counters plus an inter-pulse-interval histogram.
// Define PMT_HISTOGRAMMER_IPI_HIST_EN to build the gap counter, armed flag and ipihist bins.
module pmt_histogrammer (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        pmt,
  input  logic              resethist,
  output logic [7:0][31:0]  h,
  output logic [63:0][31:0] ipihist
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;
  localparam logic [5:0]  GAP_MAX = 6'd63;

  logic [7:0]       pmt_d_q, pmt_d_d;
  logic [7:0]       ev;
  logic [7:0][31:0] h_q, h_d;

  // pmt_d keeps loading during reset so a level held across deassertion is not an edge.
  always_comb begin
    pmt_d_d = pmt;
    ev      = pmt & ~pmt_d_q;
  end

  always_comb begin
    h_d = h_q;
    for (int i = 0; i < 8; i++) begin
      if (resethist) h_d[i] = '0;
      if (ev[i] && (h_d[i] != CNT_MAX)) h_d[i] = h_d[i] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    pmt_d_q <= pmt_d_d;
    if (reset) h_q <= '0;
    else       h_q <= h_d;
  end

  assign h = h_q;

`ifdef PMT_HISTOGRAMMER_IPI_HIST_EN
  logic              any_ev;
  logic [5:0]        gap_q, gap_d;
  logic              armed_q, armed_d;
  logic [63:0][31:0] ipi_q, ipi_d;

  // gap_q equals the cycles elapsed since the last event, so it indexes the bin directly.
  always_comb begin
    any_ev  = |ev;
    gap_d   = gap_q;
    armed_d = armed_q;
    ipi_d   = ipi_q;
    if (any_ev)                 gap_d = 6'd1;
    else if (gap_q != GAP_MAX)  gap_d = gap_q + 6'd1;
    if (resethist)              armed_d = 1'b0;
    if (any_ev)                 armed_d = 1'b1;
    if (resethist) begin
      ipi_d = '0;
    end else if (any_ev && armed_q && (ipi_q[gap_q] != CNT_MAX)) begin
      ipi_d[gap_q] = ipi_q[gap_q] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q   <= GAP_MAX;
      armed_q <= 1'b0;
      ipi_q   <= '0;
    end else begin
      gap_q   <= gap_d;
      armed_q <= armed_d;
      ipi_q   <= ipi_d;
    end
  end

  assign ipihist = ipi_q;
`else
  assign ipihist = '0;
`endif

endmodule

// File: tb/tb_pmt_histogrammer.sv
// Directed bench for pmt_histogrammer; ipihist expectations collapse to 0 unless
// PMT_HISTOGRAMMER_IPI_HIST_EN is defined for the build.
module tb_pmt_histogrammer;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        pmt;
  logic              resethist;
  logic [7:0][31:0]  h;
  logic [63:0][31:0] ipihist;

  int checks = 0;
  int errors = 0;

  logic [7:0][31:0]  exp_h;
  logic [63:0][31:0] exp_ipi;
  logic [7:0][31:0]  frc;

  always #5 clk = ~clk;

  pmt_histogrammer dut (
    .clk       (clk),
    .reset     (reset),
    .pmt       (pmt),
    .resethist (resethist),
    .h         (h),
    .ipihist   (ipihist)
  );

  function automatic logic [31:0] ipi_exp(input logic [31:0] v);
`ifdef PMT_HISTOGRAMMER_IPI_HIST_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compares every h channel and every ipihist bin against exp_h / exp_ipi.
  task automatic check_all(input string name);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s h[%0d]", name, i), h[i], exp_h[i]);
    for (int k = 0; k < 64; k++)
      check($sformatf("%s ipi[%0d]", name, k), ipihist[k], ipi_exp(exp_ipi[k]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pmt = 8'h00;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [7:0] mask);
    pmt = mask;
    tick();
    pmt = 8'h00;
    tick();
  endtask

  task automatic do_reset(input logic [7:0] hold);
    reset     = 1'b1;
    resethist = 1'b0;
    pmt       = hold;
    tick();
    tick();
    reset = 1'b0;
    exp_h   = '0;
    exp_ipi = '0;
  endtask

  initial begin
    reset     = 1'b1;
    pmt       = 8'h00;
    resethist = 1'b0;

    // Reset state
    do_reset(8'h00);
    check_all("reset");

    // Reset priority over resethist and a coincident edge
    reset = 1'b1; resethist = 1'b1; pmt = 8'hFF;
    tick();
    check("rst_prio h[0]", h[0], 32'd0);
    check("rst_prio h[7]", h[7], 32'd0);
    do_reset(8'h00);

    // Single event: level held 3 cycles counts once, visible the next cycle
    pmt = 8'h01;
    tick();
    check("single t+1 h[0]", h[0], 32'd1);
    tick();
    tick();
    idle(1);
    exp_h[0] = 32'd1;
    check_all("single");

    // Interval scenario: intervals of 5 and 85 (saturates to bin 63)
    do_reset(8'h00);
    idle(2);
    pulse(8'h04);
    idle(3);
    pulse(8'h20);
    idle(83);
    pulse(8'h04);
    exp_h[2] = 32'd2; exp_h[5] = 32'd1;
    exp_ipi[5] = 32'd1; exp_ipi[63] = 32'd1;
    check_all("interval");

    // Back-to-back: 0x00/0xFF alternating for 20 cycles
    do_reset(8'h00);
    for (int i = 0; i < 20; i++) begin
      pmt = (i % 2 == 1) ? 8'hFF : 8'h00;
      tick();
    end
    idle(1);
    for (int i = 0; i < 8; i++) exp_h[i] = 32'd10;
    exp_ipi[2] = 32'd9;
    check_all("b2b");

    // d=1 on different channels records bin 1
    do_reset(8'h00);
    pmt = 8'h01; tick();
    pmt = 8'h03; tick();
    idle(1);
    exp_h[0] = 32'd1; exp_h[1] = 32'd1; exp_ipi[1] = 32'd1;
    check_all("d1");

    // Clear collision: resethist coincident with a ch3 edge
    do_reset(8'h00);
    for (int i = 0; i < 7; i++) pulse(8'h08);
    check("preload h[3]", h[3], 32'd7);
    check("preload ipi[2]", ipihist[2], ipi_exp(32'd6));
    pmt = 8'h08; resethist = 1'b1;
    tick();
    resethist = 1'b0;
    exp_h = '0; exp_h[3] = 32'd1; exp_ipi = '0;
    check_all("clear_coll");
    idle(3);
    pmt = 8'h08;
    tick();
    exp_h[3] = 32'd2; exp_ipi[4] = 32'd1;
    check_all("after_clear");

    // Clear without an event disarms: next event is not recorded
    idle(1);
    resethist = 1'b1;
    tick();
    resethist = 1'b0;
    exp_h = '0; exp_ipi = '0;
    check_all("clear_idle");
    idle(5);
    pulse(8'h01);
    exp_h[0] = 32'd1;
    check_all("disarmed");

    // Saturation from a forced near-max count
    do_reset(8'h00);
    idle(1);
    frc    = '0;
    frc[0] = 32'hFFFF_FFFE;
    force dut.h_q = frc;
    #1;
    release dut.h_q;
    check("sat preload h[0]", h[0], 32'hFFFF_FFFE);
    pulse(8'h01);
    check("sat first h[0]", h[0], 32'hFFFF_FFFF);
    pulse(8'h01);
    pulse(8'h01);
    exp_h[0] = 32'hFFFF_FFFF; exp_ipi[2] = 32'd2;
    check_all("sat");

    // Level held across reset deassertion is not an event
    do_reset(8'h80);
    pmt = 8'h80;
    tick();
    tick();
    idle(1);
    check_all("held");
    pmt = 8'h80;
    tick();
    check("held later edge h[7]", h[7], 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmt_histogrammer.md
PMT_HISTOGRAMMER -- requirements
Module: pmt_histogrammer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, both named as the codebase does (clk, reset).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 pmt  input  8  per-channel PMT hit levels, already synchronous to clk.
REQ-005 resethist  input  1  one-cycle clear request from the serial command processor, issued on the cycle it latches the histograms.
REQ-006 h  output  8 x 32  per-channel rising-edge hit counts, unsigned.
REQ-007 ipihist  output  64 x 32  inter-pulse-interval histogram in clk cycles, unsigned.

Function
REQ-008 Per-channel event: pmt[i]=1 and pmt_d[i]=0, where pmt_d is pmt registered one cycle.
REQ-009 Any-event: OR of the 8 per-channel events in the same cycle.
REQ-010 Each channel event in cycle t SHALL make h[i] one higher from cycle t+1; coincident events on several channels increment each affected h[i].
REQ-011 Every h[i] and ipihist[k] SHALL saturate at 0xFFFFFFFF with no wrap.
REQ-012 Gap counter (6 bit) SHALL load 1 on an any-event cycle, increment on each later non-event cycle, and saturate at 63.
REQ-013 armed flag SHALL be 0 after reset or clear and SHALL set on the first any-event.
REQ-014 On an any-event with armed=1, ipihist[gap] SHALL increment (visible t+1); an interval of d cycles records bin min(d,63).
REQ-015 The first any-event after reset or clear SHALL NOT be recorded in ipihist; bin 0 is never incremented.
REQ-016 Events on consecutive cycles (d=1) SHALL record bin 1.
REQ-017 resethist=1 in cycle t SHALL make all h and ipihist 0 in cycle t+1, except that events in cycle t count into the cleared values (h[i]=1 for each channel with an event).
REQ-018 In the resethist cycle, an any-event SHALL set armed and load gap=1 but SHALL NOT write ipihist.
REQ-019 Outputs SHALL be driven directly from the counter registers, with no extra output pipeline stage.

Reset
REQ-020 While reset=1: all h and ipihist SHALL be 0, gap SHALL be 63, armed SHALL be 0, and pmt_d SHALL load pmt.
REQ-021 A pmt level held high across reset deassertion SHALL NOT produce an event.
REQ-022 reset SHALL take priority over resethist and over events in the same cycle.

Configuration
REQ-023 Macro PMT_HISTOGRAMMER_IPI_HIST_EN defined: the gap counter, armed flag and ipihist logic SHALL be built as REQ-012 to REQ-018 describe.
REQ-024 Macro not defined: ipihist SHALL be tied to 0, no gap, armed or ipihist registers SHALL exist, and h behaviour SHALL be unchanged.

Verification
REQ-025 Single-event scenario: reset, then pmt=0x01 for 3 cycles, then 0 -> h[0]=1, all other h=0, ipihist all 0.
REQ-026 Interval scenario: ch2 edge at cycle 10, ch5 edge at cycle 15, ch2 edge at cycle 100 -> ipihist[5]=1, ipihist[63]=1, h[2]=2, h[5]=1.
REQ-027 Back-to-back scenario: pmt alternates 0x00/0xFF every cycle for 20 cycles starting 0 -> h[i]=10 for all i, ipihist[2]=9.
REQ-028 Clear collision scenario: h[3]=7 preloaded via events, resethist pulse coincident with a ch3 edge -> next cycle h[3]=1, ipihist all 0; next edge 4 cycles later -> ipihist[4]=1.
REQ-029 Saturation scenario: force h[0]=0xFFFFFFFE, apply 3 ch0 edges -> h[0]=0xFFFFFFFF.
REQ-030 Reset scenario: pmt held at 0x80 through reset deassertion -> h[7]=0; macro undefined -> ipihist reads 0 in every scenario above.
